// File: rtl/svpwm_pkg.sv
// Shared types and helpers for the SVPWM zero-sequence offset sequencer.
package svpwm_pkg;

    localparam int DATA_W_DFLT = 16;

    typedef enum logic [2:0] {
        IDLE,
        C_AB,
        C_MIN,
        C_MAX,
        OFS,
        ADD,
        OUT
    } state_e;

    // Clamp a wide signed value into the signed range of a w-bit word.
    function automatic logic signed [63:0] sat_w(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi_lim;
        logic signed [63:0] lo_lim;
        hi_lim = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo_lim = -(64'sd1 <<< (w - 1));
        if (x > hi_lim)
            sat_w = hi_lim;
        else if (x < lo_lim)
            sat_w = lo_lim;
        else
            sat_w = x;
    endfunction

endpackage

// File: rtl/svpwm_cmp_unit.sv
// Shared signed comparator: orders two operands, first operand wins a tie.
module svpwm_cmp_unit #(
    parameter int W = 16
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic                le,
    output logic signed [W-1:0] lo,
    output logic signed [W-1:0] hi
);

    always_comb begin
        le = (a <= b);
        lo = le ? a : b;
        hi = le ? b : a;
    end

endmodule

// File: rtl/svpwm_offset_sequencer.sv
// Finds min/max of three phase references with one shared comparator, then adds
// the zero-sequence offset -(min+max)/2 to each phase with saturation.
module svpwm_offset_sequencer
    import svpwm_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clk_enable,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] va,
    input  logic signed [DATA_W-1:0] vb,
    input  logic signed [DATA_W-1:0] vc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] ma,
    output logic signed [DATA_W-1:0] mb,
    output logic signed [DATA_W-1:0] mc,
    output logic signed [DATA_W-1:0] vmin,
    output logic signed [DATA_W-1:0] vmax,
    output logic                     sat,
    output logic                     busy
);

    state_e                        state_q, state_d;
    logic [2:0][DATA_W-1:0]        v_q, v_d;
    logic signed [DATA_W-1:0]      lo_q, lo_d, hi_q, hi_d;
    logic signed [DATA_W-1:0]      min_q, min_d, max_q, max_d;
    logic signed [DATA_W:0]        off_q, off_d;
    logic [2:0][DATA_W-1:0]        m_q, m_d;
    logic signed [DATA_W-1:0]      vmin_q, vmin_d, vmax_q, vmax_d;
    logic                          sat_q, sat_d;
    logic                          out_valid_q, out_valid_d;

    logic signed [DATA_W-1:0]      cmp_a, cmp_b, cmp_lo, cmp_hi;
    logic                          cmp_le;
    logic signed [DATA_W:0]        sum;
    logic signed [DATA_W+1:0]      ext;
    logic signed [63:0]            clamped;
    logic                          sat_any;

    // Operand routing into the single comparator, one compare per state.
    always_comb begin
        cmp_a = $signed(v_q[0]);
        cmp_b = $signed(v_q[1]);
        case (state_q)
            C_MIN: begin
                cmp_a = lo_q;
                cmp_b = $signed(v_q[2]);
            end
            C_MAX: begin
                cmp_a = $signed(v_q[2]);
                cmp_b = hi_q;
            end
            default: ;
        endcase
    end

    svpwm_cmp_unit #(.W(DATA_W)) u_cmp (
        .a  (cmp_a),
        .b  (cmp_b),
        .le (cmp_le),
        .lo (cmp_lo),
        .hi (cmp_hi)
    );

    always_comb begin
        state_d     = state_q;
        v_d         = v_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        min_d       = min_q;
        max_d       = max_q;
        off_d       = off_q;
        m_d         = m_q;
        vmin_d      = vmin_q;
        vmax_d      = vmax_q;
        sat_d       = sat_q;
        out_valid_d = out_valid_q;
        sum         = '0;
        ext         = '0;
        clamped     = '0;
        sat_any     = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    v_d     = {vc, vb, va};
                    state_d = C_AB;
                end
            end
            C_AB: begin
                lo_d    = cmp_lo;
                hi_d    = cmp_hi;
                state_d = C_MIN;
            end
            C_MIN: begin
                min_d   = cmp_le ? cmp_a : cmp_b;
                state_d = C_MAX;
            end
            C_MAX: begin
                max_d   = cmp_hi;
                state_d = OFS;
            end
            OFS: begin
                sum     = (DATA_W+1)'(min_q) + (DATA_W+1)'(max_q);
                off_d   = -(sum >>> 1);
                state_d = ADD;
            end
            ADD: begin
                for (int i = 0; i < 3; i++) begin
                    ext     = (DATA_W+2)'($signed(v_q[i])) + (DATA_W+2)'(off_q);
                    clamped = sat_w(64'(ext), DATA_W);
                    m_d[i]  = clamped[DATA_W-1:0];
                    if (clamped != 64'(ext))
                        sat_any = 1'b1;
                end
                vmin_d      = min_q;
                vmax_d      = max_q;
                sat_d       = sat_any;
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            v_q         <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
            min_q       <= '0;
            max_q       <= '0;
            off_q       <= '0;
            m_q         <= '0;
            vmin_q      <= '0;
            vmax_q      <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (clk_enable) begin
            state_q     <= state_d;
            v_q         <= v_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            min_q       <= min_d;
            max_q       <= max_d;
            off_q       <= off_d;
            m_q         <= m_d;
            vmin_q      <= vmin_d;
            vmax_q      <= vmax_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign ma        = m_q[0];
    assign mb        = m_q[1];
    assign mc        = m_q[2];
    assign vmin      = vmin_q;
    assign vmax      = vmax_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_svpwm_offset_sequencer.sv
// Directed bench for svpwm_offset_sequencer with an expected-result queue.
module tb_svpwm_offset_sequencer;

    localparam int DW = 16;

    logic                 clk = 1'b0;
    logic                 reset, clk_enable, in_valid, out_ready;
    logic signed [DW-1:0] va, vb, vc;
    logic                 in_ready, out_valid, sat, busy;
    logic signed [DW-1:0] ma, mb, mc, vmin, vmax;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int ma, mb, mc, vmin, vmax, sat;
    } exp_t;
    exp_t sbq[$];

    svpwm_offset_sequencer #(.DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable),
        .in_valid(in_valid), .in_ready(in_ready),
        .va(va), .vb(vb), .vc(vc),
        .out_valid(out_valid), .out_ready(out_ready),
        .ma(ma), .mb(mb), .mc(mc), .vmin(vmin), .vmax(vmax),
        .sat(sat), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int clampw(int x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    function automatic exp_t model(int a, int b, int c);
        exp_t e;
        int mn, mx, off;
        mn = a; if (b < mn) mn = b; if (c < mn) mn = c;
        mx = a; if (b > mx) mx = b; if (c > mx) mx = c;
        off    = -((mn + mx) >>> 1);
        e.ma   = clampw(a + off);
        e.mb   = clampw(b + off);
        e.mc   = clampw(c + off);
        e.vmin = mn;
        e.vmax = mx;
        e.sat  = ((e.ma != a + off) || (e.mb != b + off) || (e.mc != c + off)) ? 1 : 0;
        return e;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a sample and return just after the edge that accepts it.
    task automatic send(input string tag, input int a, input int b, input int c);
        int n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        va = 16'(a); vb = 16'(b); vc = 16'(c);
        in_valid = 1'b1;
        sbq.push_back(model(a, b, c));
        step();
        in_valid = 1'b0;
        va = 16'($urandom); vb = 16'($urandom); vc = 16'($urandom);
    endtask

    task automatic collect(input string tag, input int lat);
        int n = 0;
        exp_t e;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_latency"}, n, lat);
        chk({tag, "_sb_pending"}, int'(sbq.size() > 0), 1);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk({tag, "_ma"}, int'(ma), e.ma);
            chk({tag, "_mb"}, int'(mb), e.mb);
            chk({tag, "_mc"}, int'(mc), e.mc);
            chk({tag, "_vmin"}, int'(vmin), e.vmin);
            chk({tag, "_vmax"}, int'(vmax), e.vmax);
            chk({tag, "_sat"}, int'(sat), e.sat);
        end
        chk({tag, "_busy_out"}, int'(busy), 1);
        chk({tag, "_in_ready_out"}, int'(in_ready), 0);
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, int'(out_valid), 0);
        chk({tag, "_idle"}, int'(in_ready), 1);
    endtask

    initial begin
        int held_ma, held_mb;
        int ra, rb, rc;
        reset = 1'b1; clk_enable = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        va = '0; vb = '0; vc = '0;

        // Reset wins even with the enable low.
        step();
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_ma", int'(ma), 0);
        chk("rst_vmin", int'(vmin), 0);
        chk("rst_vmax", int'(vmax), 0);
        chk("rst_sat", int'(sat), 0);
        reset = 1'b0; clk_enable = 1'b1;
        step();

        send("t1", 1000, -500, 200);
        collect("t1", 5);
        chk("t1_ma_const", int'(ma), 750);
        chk("t1_mc_const", int'(mc), -50);
        release_out("t1");

        send("t2", 100, 100, 100);
        collect("t2", 5);
        release_out("t2");

        send("t3", 32767, -32768, 0);
        collect("t3", 5);
        chk("t3_sat_const", int'(sat), 1);
        chk("t3_ma_const", int'(ma), 32767);
        release_out("t3");

        // Back-pressure with stray in_valid pulses.
        send("t4", 300, -100, 50);
        collect("t4", 5);
        held_ma = int'(ma);
        held_mb = int'(mb);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            va = 16'($urandom); vb = 16'($urandom); vc = 16'($urandom);
            step();
            chk("t4_hold_valid", int'(out_valid), 1);
            chk("t4_hold_ma", int'(ma), held_ma);
            chk("t4_hold_mb", int'(mb), held_mb);
            chk("t4_hold_ready", int'(in_ready), 0);
        end
        in_valid = 1'b0;
        release_out("t4");
        chk("t4_no_extra", sbq.size(), 0);

        // Abort a sample in C_MAX.
        send("t5a", -2000, 700, 1500);
        step();
        step();
        chk("t5_busy_pre", int'(busy), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        void'(sbq.pop_back());
        chk("t5_in_ready", int'(in_ready), 1);
        chk("t5_busy", int'(busy), 0);
        chk("t5_out_valid", int'(out_valid), 0);
        chk("t5_ma", int'(ma), 0);
        chk("t5_mb", int'(mb), 0);
        chk("t5_mc", int'(mc), 0);
        chk("t5_vmax", int'(vmax), 0);
        send("t5b", 1000, -500, 200);
        collect("t5b", 5);
        release_out("t5b");

        // Enable gap while in C_MIN.
        send("t6", 1000, -500, 200);
        step();
        clk_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_frozen_busy", int'(busy), 1);
            chk("t6_frozen_valid", int'(out_valid), 0);
        end
        clk_enable = 1'b1;
        collect("t6", 4);
        release_out("t6");

        for (int k = 0; k < 4; k++) begin
            ra = int'($signed(16'($urandom)));
            rb = int'($signed(16'($urandom)));
            rc = int'($signed(16'($urandom)));
            send("rnd", ra, rb, rc);
            collect("rnd", 5);
            release_out("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
